// File: rtl/id_ex_hazard_unit.sv
// ID/EX pipeline register for specifiers and controls, with load-use stall detection,
// mispredict squash, EX operand forwarding selects and saturating stall/flush counters.
module id_ex_hazard_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    input  logic [REG_AW-1:0] ex_mem_rd,
    input  logic              ex_mem_reg_write,
    input  logic [REG_AW-1:0] mem_wb_rd,
    input  logic              mem_wb_reg_write,
    output logic              stall,
    output logic              ex_valid,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic [1:0]        fwd_sel_a,
    output logic [1:0]        fwd_sel_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic rs_hit;
    logic rt_hit;
    logic bubble;

    // A load in EX whose destination an ID source needs: hold ID one cycle so the
    // consumer later picks the loaded value up from MEM/WB.
    always_comb begin
        rs_hit = id_uses_rs && (id_rs == ex_rd);
        rt_hit = id_uses_rt && (id_rt == ex_rd);
        stall  = !flush && id_valid && ex_valid && ex_mem_read &&
                 (ex_rd != '0) && (rs_hit || rt_hit);
        bubble = flush || stall;
    end

    // Newest producer wins; register 0 is hardwired and never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
        logic [1:0] sel;
        sel = 2'b00;
        if (ex_mem_reg_write && (ex_mem_rd != '0) && (ex_mem_rd == src))
            sel = 2'b01;
        else if (mem_wb_reg_write && (mem_wb_rd != '0) && (mem_wb_rd == src))
            sel = 2'b10;
        return sel;
    endfunction

    always_comb begin
        fwd_sel_a = 2'b00;
        fwd_sel_b = 2'b00;
        if (ex_valid) begin
            fwd_sel_a = fwd_sel(ex_rs);
            fwd_sel_b = fwd_sel(ex_rt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            ex_rs        <= '0;
            ex_rt        <= '0;
            ex_rd        <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
        end else if (bubble) begin
            ex_valid     <= 1'b0;
            ex_rs        <= '0;
            ex_rt        <= '0;
            ex_rd        <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
        end else begin
            ex_valid     <= id_valid;
            ex_rs        <= id_rs;
            ex_rt        <= id_rt;
            ex_rd        <= id_rd;
            ex_reg_write <= id_reg_write && id_valid;
            ex_mem_read  <= id_mem_read && id_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != CNT_MAX))
                stall_cnt <= stall_cnt + CNT_ONE;
            if (flush && id_valid && (flush_cnt != CNT_MAX))
                flush_cnt <= flush_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_id_ex_hazard_unit.sv
// Bench for id_ex_hazard_unit: directed hazard scenarios followed by random traffic,
// all checked against a rule-level reference model of the EX stage.
module tb_id_ex_hazard_unit;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              id_valid = 1'b0;
    logic [REG_AW-1:0] id_rs = '0;
    logic [REG_AW-1:0] id_rt = '0;
    logic              id_uses_rs = 1'b0;
    logic              id_uses_rt = 1'b0;
    logic [REG_AW-1:0] id_rd = '0;
    logic              id_reg_write = 1'b0;
    logic              id_mem_read = 1'b0;
    logic              flush = 1'b0;
    logic [REG_AW-1:0] ex_mem_rd = '0;
    logic              ex_mem_reg_write = 1'b0;
    logic [REG_AW-1:0] mem_wb_rd = '0;
    logic              mem_wb_reg_write = 1'b0;
    logic              stall;
    logic              ex_valid;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic [1:0]        fwd_sel_a;
    logic [1:0]        fwd_sel_b;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    int tests = 0;
    int failed = 0;

    // Reference model of what EX holds, as plain integers.
    int m_valid, m_rs, m_rt, m_rd, m_rw, m_mr, m_scnt, m_fcnt;

    id_ex_hazard_unit #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
        .ex_mem_rd(ex_mem_rd), .ex_mem_reg_write(ex_mem_reg_write),
        .mem_wb_rd(mem_wb_rd), .mem_wb_reg_write(mem_wb_reg_write),
        .stall(stall), .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_stall();
        int needs;
        if (flush) return 0;
        needs = 0;
        if (id_uses_rs && int'(id_rs) == m_rd) needs = 1;
        if (id_uses_rt && int'(id_rt) == m_rd) needs = 1;
        return (id_valid && m_valid == 1 && m_mr == 1 && m_rd != 0 && needs == 1) ? 1 : 0;
    endfunction

    function automatic int exp_fwd(input int src);
        if (m_valid == 0) return 0;
        if (ex_mem_reg_write && ex_mem_rd != 0 && int'(ex_mem_rd) == src) return 1;
        if (mem_wb_reg_write && mem_wb_rd != 0 && int'(mem_wb_rd) == src) return 2;
        return 0;
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_rs = 0; m_rt = 0; m_rd = 0; m_rw = 0; m_mr = 0;
        m_scnt = 0; m_fcnt = 0;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".ex_valid"}, 32'(ex_valid), 32'(m_valid));
        chk({tag, ".ex_rs"}, 32'(ex_rs), 32'(m_rs));
        chk({tag, ".ex_rt"}, 32'(ex_rt), 32'(m_rt));
        chk({tag, ".ex_rd"}, 32'(ex_rd), 32'(m_rd));
        chk({tag, ".ex_reg_write"}, 32'(ex_reg_write), 32'(m_rw));
        chk({tag, ".ex_mem_read"}, 32'(ex_mem_read), 32'(m_mr));
        chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_scnt));
        chk({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(m_fcnt));
    endtask

    // One clock: check combinational outputs, clock the model alongside the DUT, check state.
    task automatic step(input string tag);
        int s;
        #1;
        s = exp_stall();
        chk({tag, ".stall"}, 32'(stall), 32'(s));
        chk({tag, ".fwd_sel_a"}, 32'(fwd_sel_a), 32'(exp_fwd(m_rs)));
        chk({tag, ".fwd_sel_b"}, 32'(fwd_sel_b), 32'(exp_fwd(m_rt)));
        @(posedge clk);
        if (s == 1) m_scnt = sat_inc(m_scnt);
        if (flush && id_valid) m_fcnt = sat_inc(m_fcnt);
        if (flush || s == 1) begin
            m_valid = 0; m_rs = 0; m_rt = 0; m_rd = 0; m_rw = 0; m_mr = 0;
        end else begin
            m_valid = int'(id_valid);
            m_rs = int'(id_rs);
            m_rt = int'(id_rt);
            m_rd = int'(id_rd);
            m_rw = int'(id_reg_write && id_valid);
            m_mr = int'(id_mem_read && id_valid);
        end
        #1;
        check_regs(tag);
    endtask

    // Asynchronous reset asserted between edges; everything must clear at once.
    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_regs(tag);
        chk({tag, ".stall"}, 32'(stall), 32'd0);
        chk({tag, ".fwd_sel_a"}, 32'(fwd_sel_a), 32'd0);
        chk({tag, ".fwd_sel_b"}, 32'(fwd_sel_b), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_id(input logic v, input int rs, input int rt, input logic urs,
                          input logic urt, input int rd, input logic rw, input logic mr,
                          input logic fl);
        id_valid = v;
        id_rs = REG_AW'(rs);
        id_rt = REG_AW'(rt);
        id_uses_rs = urs;
        id_uses_rt = urt;
        id_rd = REG_AW'(rd);
        id_reg_write = rw;
        id_mem_read = mr;
        flush = fl;
    endtask

    task automatic set_fwd(input int emr, input logic emw, input int mwr, input logic mww);
        ex_mem_rd = REG_AW'(emr);
        ex_mem_reg_write = emw;
        mem_wb_rd = REG_AW'(mwr);
        mem_wb_reg_write = mww;
    endtask

    initial begin
        model_reset();
        // Reset held from time 0
        #1;
        check_regs("por");
        chk("por.stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // EX/MEM beats MEM/WB, then MEM/WB alone
        set_id(1, 5, 6, 1, 1, 7, 1, 0, 0);
        step("fwd_cap");
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_fwd(5, 1, 5, 1);
        #1;
        chk("fwd_exmem", 32'(fwd_sel_a), 32'd1);
        set_fwd(5, 0, 5, 1);
        #1;
        chk("fwd_memwb", 32'(fwd_sel_a), 32'd2);
        step("fwd_drain");

        // Load-use on $8: one stall, bubble, then consumer forwards from MEM/WB
        set_fwd(0, 0, 0, 0);
        set_id(1, 0, 0, 0, 0, 8, 1, 1, 0);
        step("lw8");
        set_id(1, 8, 9, 1, 1, 10, 1, 0, 0);
        #1;
        chk("lu_stall", 32'(stall), 32'd1);
        step("lu_bubble");
        chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
        set_fwd(0, 0, 8, 1);
        #1;
        chk("lu_released", 32'(stall), 32'd0);
        step("lu_consumer");
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("lu_fwd_a", 32'(fwd_sel_a), 32'd2);
        chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        step("lu_drain");

        // Register $0 never forwarded and never a load-use hazard
        set_id(1, 0, 0, 1, 1, 3, 1, 0, 0);
        step("zero_cap");
        set_fwd(0, 1, 0, 1);
        #1;
        chk("zero_fwd_b", 32'(fwd_sel_b), 32'd0);
        set_fwd(0, 0, 0, 0);
        set_id(1, 0, 0, 0, 0, 0, 1, 1, 0);
        step("lw0");
        set_id(1, 0, 0, 1, 1, 4, 1, 0, 0);
        #1;
        chk("zero_no_stall", 32'(stall), 32'd0);
        step("use0");

        // Flush and load-use together: flush wins
        do_reset("rst_a");
        set_id(1, 0, 0, 0, 0, 8, 1, 1, 0);
        step("lw8b");
        set_id(1, 8, 0, 1, 0, 11, 1, 0, 1);
        #1;
        chk("fl_stall", 32'(stall), 32'd0);
        step("fl_cycle");
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("fl_bubble", 32'(ex_valid), 32'd0);
        chk("fl_flush_cnt", 32'(flush_cnt), 32'd1);
        chk("fl_stall_cnt", 32'(stall_cnt), 32'd0);

        // Back-to-back dependent loads stall every other cycle: 20 stalls saturate at 15
        do_reset("rst_b");
        set_id(1, 8, 0, 1, 0, 8, 1, 1, 0);
        for (int i = 0; i < 41; i++) step("sat");
        chk("sat_stall_cnt", 32'(stall_cnt), 32'(CMAX));

        // Mid-stall reset: stall must drop asynchronously
        do_reset("rst_c");
        step("rst_c_lw");
        #1;
        chk("midstall_pre", 32'(stall), 32'd1);
        do_reset("rst_mid");

        // Random traffic over a small register range so hazards are frequent
        for (int i = 0; i < 400; i++) begin
            set_id(($urandom_range(0, 7) != 0), $urandom_range(0, 3), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                   ($urandom_range(0, 7) == 0));
            set_fwd($urandom_range(0, 3), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 63) == 0) do_reset("rnd_rst");
            else step("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
